// File: rtl/seq_ctrl_pkg.sv
// Shared types and default widths for the sequence-detector run controller.
//   state_e       : run-controller FSM states
//   DEF_*         : default parameter values for MAX_LEN, CNT_W, TMO_W and LEN_W
//   len_is_legal  : true when a pattern length lies in 1..max_len
package seq_ctrl_pkg;

  localparam int unsigned DEF_MAX_LEN = 8;
  localparam int unsigned DEF_CNT_W   = 8;
  localparam int unsigned DEF_TMO_W   = 16;
  localparam int unsigned DEF_LEN_W   = $clog2(DEF_MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic len_is_legal(input int unsigned len, input int unsigned max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Serial pattern matcher: shift history, valid-bit count and length-masked compare.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   shift_en   : accept 'in' this cycle (controller is running)
//   clear      : wipe history and valid count (start of a run)
//   in         : serial data bit, newest bit enters the LSB
//   pattern    : reference pattern, bit [len-1] is the oldest bit
//   len        : active pattern length (1..MAX_LEN)
//   overlap    : 1 = matches may share bits, 0 = restart after each match
//   match      : combinational, high when the bit on 'in' completes a match
module seq_match_core
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned  MAX_LEN = DEF_MAX_LEN,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en,
  input  logic               clear,
  input  logic               in,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               match
);

  logic [MAX_LEN-1:0] history;
  logic [LEN_W-1:0]   valid_cnt;
  logic [MAX_LEN-1:0] cand_c;
  logic [LEN_W-1:0]   cand_valid_c;
  logic [MAX_LEN-1:0] mask_c;

  // The match is judged on the history as it will be after this cycle's bit,
  // so the registered detected pulse lands one cycle after the completing bit.
  always_comb begin
    cand_c       = {history[MAX_LEN-2:0], in};
    cand_valid_c = (valid_cnt >= len) ? len : LEN_W'(valid_cnt + LEN_W'(1));
    mask_c       = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask_c[i] = (i < 32'(len));
    end
    match = shift_en && (cand_valid_c >= len) && (((cand_c ^ pattern) & mask_c) == '0);
  end

  // History and valid count; a non-overlapping match discards all used bits.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      history   <= '0;
      valid_cnt <= '0;
    end else if (shift_en) begin
      history   <= cand_c;
      valid_cnt <= (match && !overlap) ? '0 : cand_valid_c;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for a programmable Moore sequence detector on a serial stream.
// Holds the pattern configuration, sequences arm/count/finish and reports status.
// Optional feature macro: MATCH_TIMEOUT_EN (inactivity timeout; without it the
// timeout flag is tied low and cfg_timeout is unused).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   cfg_we          : load cfg_* registers (IDLE only)
//   cfg_pattern     : pattern, bit [len-1] received first
//   cfg_len         : pattern length, legal 1..MAX_LEN
//   cfg_overlap     : 1 = overlapping detection
//   cfg_target      : matches that finish a run, 0 = run until abort
//   cfg_timeout     : inactivity limit in cycles, 0 = disabled
//   start, abort    : one-cycle run control pulses (abort wins)
//   in              : serial data bit, sampled in RUN
//   busy            : high in RUN
//   detected        : one-cycle pulse per match
//   match_cnt       : saturating match count of the current run
//   done            : high in DONE
//   timeout         : sticky, run ended by inactivity
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned  MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned  CNT_W   = DEF_CNT_W,
  parameter int unsigned  TMO_W   = DEF_TMO_W,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic [TMO_W-1:0]   cfg_timeout,
  input  logic               start,
  input  logic               abort,
  input  logic               in,
  output logic               busy,
  output logic               detected,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               done,
  output logic               timeout
);

  state_e state, state_next;

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [CNT_W-1:0]   target_q;

  logic               cfg_load_c;
  logic [LEN_W-1:0]   eff_len_c;
  logic               len_ok_c;
  logic               run_c;
  logic               enter_run_c;
  logic               match_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic               target_hit_c;
  logic               tmo_hit_c;

  logic               busy_next;
  logic               detected_next;
  logic [CNT_W-1:0]   match_cnt_next;
  logic               done_next;
  logic               timeout_next;

  // A write in the same cycle as start must be the length the run is judged on.
  assign cfg_load_c  = (state == IDLE) && cfg_we;
  assign eff_len_c   = cfg_load_c ? cfg_len : len_q;
  assign len_ok_c    = len_is_legal(32'(eff_len_c), MAX_LEN);
  assign run_c       = (state == RUN) && !abort;
  assign enter_run_c = (state != RUN) && (state_next == RUN);

  assign cnt_inc_c    = (&match_cnt) ? match_cnt : CNT_W'(match_cnt + CNT_W'(1));
  assign target_hit_c = match_c && (target_q != '0) && (cnt_inc_c == target_q);

  // Configuration registers, writable only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      target_q  <= '0;
    end else if (cfg_load_c) begin
      pattern_q <= cfg_pattern;
      len_q     <= cfg_len;
      overlap_q <= cfg_overlap;
      target_q  <= cfg_target;
    end
  end

  seq_match_core #(
    .MAX_LEN (MAX_LEN)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .shift_en (run_c),
    .clear    (enter_run_c),
    .in       (in),
    .pattern  (pattern_q),
    .len      (len_q),
    .overlap  (overlap_q),
    .match    (match_c)
  );

`ifdef MATCH_TIMEOUT_EN
  logic [TMO_W-1:0] timeout_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_inc_c;

  // Idle-cycle counter: restarts on every match, saturates at all-ones.
  assign tmo_inc_c = match_c   ? '0 :
                     (&tmo_cnt) ? tmo_cnt : TMO_W'(tmo_cnt + TMO_W'(1));
  assign tmo_hit_c = run_c && (timeout_q != '0) && (tmo_inc_c == timeout_q);

  always_ff @(posedge clk) begin
    if (rst || enter_run_c) begin
      tmo_cnt <= '0;
    end else if (run_c) begin
      tmo_cnt <= tmo_inc_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_q <= '0;
    end else if (cfg_load_c) begin
      timeout_q <= cfg_timeout;
    end
  end
`else
  logic unused_cfg_timeout;
  assign unused_cfg_timeout = ^cfg_timeout;
  assign tmo_hit_c          = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort overrides everything, including start.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start && len_ok_c) state_next = RUN;
        RUN:     if (target_hit_c || tmo_hit_c) state_next = DONE;
        DONE:    if (start && len_ok_c) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output next-values; status flags follow the state being entered.
  always_comb begin
    busy_next      = (state_next == RUN);
    done_next      = (state_next == DONE);
    detected_next  = match_c;
    match_cnt_next = match_cnt;
    timeout_next   = timeout;
    if (abort || enter_run_c) begin
      match_cnt_next = '0;
      timeout_next   = 1'b0;
    end else if (run_c) begin
      if (match_c) match_cnt_next = cnt_inc_c;
      if (tmo_hit_c) timeout_next = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      detected  <= 1'b0;
      match_cnt <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      busy      <= busy_next;
      detected  <= detected_next;
      match_cnt <= match_cnt_next;
      done      <= done_next;
      timeout   <= timeout_next;
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed scenarios plus randomized
// runs compared against a bit-queue reference model.
module tb_seq_detect_ctrl;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TMO_W   = 16;
  localparam int unsigned LEN_W   = 4;
`ifdef MATCH_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
  logic [TMO_W-1:0]   cfg_timeout;
  logic               start;
  logic               abort;
  logic               din;
  logic               busy;
  logic               detected;
  logic [CNT_W-1:0]   match_cnt;
  logic               done;
  logic               timeout;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int           m_state;
  bit [7:0]     m_pat;
  int           m_len;
  bit           m_ovl;
  int           m_tgt;
  int           m_tmo;
  int           m_cnt;
  int           m_idle;
  bit           m_det;
  bit           m_tflag;
  bit           hist[$];

  always #5 clk = ~clk;

  seq_detect_ctrl #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W),
    .TMO_W   (TMO_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .cfg_timeout (cfg_timeout),
    .start       (start),
    .abort       (abort),
    .in          (din),
    .busy        (busy),
    .detected    (detected),
    .match_cnt   (match_cnt),
    .done        (done),
    .timeout     (timeout)
  );

  task automatic model_reset();
    m_state = M_IDLE; m_pat = '0; m_len = 0; m_ovl = 0; m_tgt = 0; m_tmo = 0;
    m_cnt = 0; m_idle = 0; m_det = 0; m_tflag = 0;
    hist.delete();
  endtask

  // Last m_len received bits equal the pattern (newest bit against pattern[0]).
  function automatic bit tail_matches();
    for (int j = 0; j < m_len; j++) begin
      if (hist[hist.size() - 1 - j] != m_pat[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge(input bit st, input bit ab, input bit we, input bit b);
    m_det = 1'b0;
    if (m_state == M_IDLE && we) begin
      m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
      m_tgt = int'(cfg_target); m_tmo = int'(cfg_timeout);
    end
    if (ab) begin
      m_state = M_IDLE; m_cnt = 0; m_tflag = 0;
    end else if (m_state == M_RUN) begin
      hist.push_back(b);
      if (hist.size() >= m_len && tail_matches()) begin
        m_det  = 1'b1;
        m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_idle = 0;
        if (!m_ovl) hist.delete();
        if (m_tgt != 0 && m_cnt == m_tgt) m_state = M_DONE;
      end else begin
        m_idle++;
        if (TMO_EN && m_tmo != 0 && m_idle == m_tmo) begin
          m_state = M_DONE; m_tflag = 1'b1;
        end
      end
      if (hist.size() > MAX_LEN) void'(hist.pop_front());
    end else if (st && m_len >= 1 && m_len <= int'(MAX_LEN)) begin
      hist.delete(); m_cnt = 0; m_idle = 0; m_tflag = 0; m_state = M_RUN;
    end
  endtask

  task automatic set_cfg(input bit [7:0] pat, input int len, input bit ovl, input int tgt, input int tmo);
    cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_overlap = ovl;
    cfg_target = CNT_W'(tgt); cfg_timeout = TMO_W'(tmo);
  endtask

  // One clock: drive inputs, advance model at the edge, leave us 1 time unit after it.
  task automatic step(input bit st, input bit ab, input bit we, input bit b);
    start = st; abort = ab; cfg_we = we; din = b;
    @(posedge clk);
    model_edge(st, ab, we, b);
    #1;
    start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (detected !== 1'b0) begin failures++; $display("FAIL reset_detected: got %b want 0", detected); end
    checks++; if (match_cnt !== 8'd0) begin failures++; $display("FAIL reset_match_cnt: got %0d want 0", match_cnt); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    rst = 1'b0;
    step(1, 0, 0, 1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_len0_start: busy got %b want 0", busy); end
  endtask

  task automatic test_overlap();
    bit [6:0] stream = 7'b1011011;
    set_cfg(8'b1011, 4, 1, 0, 0);
    step(1, 0, 1, 0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ovl_start_busy: got %b want 1", busy); end
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, stream[6-i]);
      checks++;
      if (detected !== (i == 3 || i == 6)) begin
        failures++; $display("FAIL ovl_detected bit%0d: got %b want %b", i + 1, detected, (i == 3 || i == 6));
      end
    end
    checks++; if (match_cnt !== 8'd2) begin failures++; $display("FAIL ovl_match_cnt: got %0d want 2", match_cnt); end
    step(0, 1, 0, 0);
    checks++; if (busy !== 1'b0 || match_cnt !== 8'd0) begin
      failures++; $display("FAIL ovl_abort: busy=%b cnt=%0d want busy=0 cnt=0", busy, match_cnt);
    end
  endtask

  task automatic test_nonoverlap();
    bit [6:0] stream = 7'b1011011;
    set_cfg(8'b1011, 4, 0, 0, 0);
    step(1, 0, 1, 0);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, stream[6-i]);
      checks++;
      if (detected !== (i == 3)) begin
        failures++; $display("FAIL novl_detected bit%0d: got %b want %b", i + 1, detected, (i == 3));
      end
    end
    checks++; if (match_cnt !== 8'd1) begin failures++; $display("FAIL novl_match_cnt: got %0d want 1", match_cnt); end
    step(0, 1, 0, 0);
  endtask

  task automatic test_target();
    bit [7:0] stream = 8'b10111011;
    bit [3:0] tail   = 4'b1011;
    set_cfg(8'b1011, 4, 1, 2, 0);
    step(1, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, stream[7-i]);
      checks++;
      if (detected !== (i == 3 || i == 7)) begin
        failures++; $display("FAIL tgt_detected bit%0d: got %b want %b", i + 1, detected, (i == 3 || i == 7));
      end
      if (i == 3) begin
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin
          failures++; $display("FAIL tgt_first_match_state: done=%b busy=%b want done=0 busy=1", done, busy);
        end
      end
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || match_cnt !== 8'd2) begin
      failures++; $display("FAIL tgt_reach: done=%b busy=%b cnt=%0d want done=1 busy=0 cnt=2", done, busy, match_cnt);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, tail[3-i]);
    checks++; if (match_cnt !== 8'd2 || detected !== 1'b0 || done !== 1'b1) begin
      failures++; $display("FAIL tgt_hold_in_done: cnt=%0d det=%b done=%b want cnt=2 det=0 done=1", match_cnt, detected, done);
    end
    step(1, 1, 0, 0);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || match_cnt !== 8'd0) begin
      failures++; $display("FAIL start_abort_in_done: busy=%b done=%b cnt=%0d want 0 0 0", busy, done, match_cnt);
    end
  endtask

  task automatic test_cfg_ignored();
    bit [3:0] pat = 4'b1011;
    set_cfg(8'b1011, 4, 1, 0, 0);
    step(1, 0, 1, 0);
    set_cfg(8'b0000, 4, 1, 0, 0);
    step(0, 0, 1, 0);
    checks++; if (detected !== 1'b0) begin failures++; $display("FAIL cfgrun_zero1: detected got %b want 0", detected); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0);
      checks++; if (detected !== 1'b0) begin failures++; $display("FAIL cfgrun_zeros: detected got %b want 0", detected); end
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, pat[3-i]);
    checks++; if (detected !== 1'b1) begin failures++; $display("FAIL cfgrun_old_pattern: detected got %b want 1", detected); end
    step(0, 1, 0, 0);
    set_cfg(8'b1011, 0, 1, 0, 0);
    step(1, 0, 1, 0);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_len0: busy got %b want 0", busy); end
    set_cfg(8'b1011, 9, 1, 0, 0);
    step(1, 0, 1, 0);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_len9: busy got %b want 0", busy); end
    set_cfg(8'b1, 1, 1, 0, 0);
    step(1, 0, 1, 1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_len1: busy got %b want 1", busy); end
    step(0, 0, 0, 1);
    checks++; if (detected !== 1'b1 || match_cnt !== 8'd1) begin
      failures++; $display("FAIL len1_match: det=%b cnt=%0d want det=1 cnt=1", detected, match_cnt);
    end
    step(0, 1, 0, 0);
  endtask

  task automatic test_reset_midrun();
    bit [3:0] pat = 4'b1011;
    set_cfg(8'b1011, 4, 1, 0, 0);
    step(1, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, pat[3-i]);
    checks++; if (detected !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL midrun_pre: det=%b busy=%b want 1 1", detected, busy);
    end
    rst = 1'b1; din = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    checks++; if ({busy, detected, done, timeout, match_cnt} !== 12'd0) begin
      failures++; $display("FAIL midrun_reset: busy=%b det=%b done=%b tmo=%b cnt=%0d want all 0", busy, detected, done, timeout, match_cnt);
    end
    step(1, 0, 0, 1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrun_cfg_cleared: busy got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    set_cfg(8'b1011, 4, 1, 0, 5);
    step(1, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0);
      checks++;
      if (done !== (TMO_EN && i >= 4) || timeout !== (TMO_EN && i >= 4) || busy !== !(TMO_EN && i >= 4)) begin
        failures++;
        $display("FAIL timeout cycle%0d: done=%b tmo=%b busy=%b want done=%b tmo=%b busy=%b", i + 1,
                 done, timeout, busy, (TMO_EN && i >= 4), (TMO_EN && i >= 4), !(TMO_EN && i >= 4));
      end
    end
    step(0, 1, 0, 0);
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_abort_clear: got %b want 0", timeout); end
  endtask

  task automatic rand_cfg();
    int sel = int'($urandom_range(0, 9));
    if (sel == 0)      cfg_len = LEN_W'($urandom_range(9, 15));
    else if (sel == 1) cfg_len = LEN_W'(0);
    else if (sel < 4)  cfg_len = LEN_W'($urandom_range(5, 8));
    else               cfg_len = LEN_W'($urandom_range(1, 4));
    cfg_pattern = MAX_LEN'($urandom);
    cfg_overlap = 1'($urandom);
    cfg_target  = CNT_W'($urandom_range(0, 4));
    cfg_timeout = ($urandom_range(0, 1) == 1) ? TMO_W'(0) : TMO_W'($urandom_range(2, 12));
  endtask

  task automatic test_random();
    bit st, ab, we;
    for (int r = 0; r < 40; r++) begin
      rand_cfg();
      for (int c = 0; c < 51; c++) begin
        if (c == 0) begin
          step(1, 0, 1, 1'($urandom));
        end else begin
          st = ($urandom_range(0, 24) == 0);
          ab = ($urandom_range(0, 39) == 0);
          we = ($urandom_range(0, 14) == 0);
          if (we) rand_cfg();
          step(st, ab, we, 1'($urandom));
        end
        checks++;
        if ({busy, detected, done, timeout, match_cnt} !==
            {(m_state == M_RUN), m_det, (m_state == M_DONE), m_tflag, CNT_W'(m_cnt)}) begin
          failures++;
          $display("FAIL random r%0d c%0d: got busy=%b det=%b done=%b tmo=%b cnt=%0d want busy=%b det=%b done=%b tmo=%b cnt=%0d",
                   r, c, busy, detected, done, timeout, match_cnt,
                   (m_state == M_RUN), m_det, (m_state == M_DONE), m_tflag, m_cnt);
        end
      end
      step(0, 1, 0, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_we = 1'b0; din = 1'b0;
    set_cfg(8'd0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_target();
    test_cfg_ignored();
    test_reset_midrun();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
